// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: 1-cycle ID->EX, load-use bubble plus combinational stall, hold freezes EX.
// Optional bubble/flush counters are built when ID_EX_PERF_CNT_EN is defined.
package id_ex_pkg;
    typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_op_t;
    typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMREAD, WRSRC_PC4, WRSRC_IMM} reg_wr_src_t;
    typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} alu_src1_t;
    typedef enum logic [1:0] {SRC2_REG2, SRC2_IMM, SRC2_FOUR} alu_src2_t;
    typedef enum logic [3:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                              ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU} alu_op_t;
    typedef enum logic [3:0] {MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
                              MEM_SB, MEM_SH, MEM_SW} mem_op_t;

    typedef struct packed {
        logic        reg_do_write;
        logic        mem_do_write;
        logic        mem_do_read;
        logic        do_branch;
        logic        do_jump;
        comp_op_t    comp;
        reg_wr_src_t wr_src;
        alu_src1_t   op1;
        alu_src2_t   op2;
        alu_op_t     alu;
        mem_op_t     mem;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{reg_do_write: 1'b0, mem_do_write: 1'b0, mem_do_read: 1'b0,
                                   do_branch: 1'b0, do_jump: 1'b0, comp: BR_NOP,
                                   wr_src: WRSRC_ALURES, op1: SRC1_REG1, op2: SRC2_REG2,
                                   alu: ALU_NOP, mem: MEM_NOP};
endpackage

module id_ex_pipe_reg
    import id_ex_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid_i,
    input  logic                  id_reg_do_write_ctrl,
    input  logic                  id_mem_do_write_ctrl,
    input  logic                  id_mem_do_read_ctrl,
    input  logic                  id_do_branch,
    input  logic                  id_do_jump,
    input  comp_op_t              id_comp_ctrl,
    input  reg_wr_src_t           id_reg_wr_src_ctrl,
    input  alu_src1_t             id_alu_op1_ctrl,
    input  alu_src2_t             id_alu_op2_ctrl,
    input  alu_op_t               id_alu_ctrl,
    input  mem_op_t               id_mem_ctrl,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [XLEN-1:0]       id_reg1_data,
    input  logic [XLEN-1:0]       id_reg2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [XLEN-1:0]       id_pc,
    output logic                  ex_reg_do_write_ctrl,
    output logic                  ex_mem_do_write_ctrl,
    output logic                  ex_mem_do_read_ctrl,
    output logic                  ex_do_branch,
    output logic                  ex_do_jump,
    output comp_op_t              ex_comp_ctrl,
    output reg_wr_src_t           ex_reg_wr_src_ctrl,
    output alu_src1_t             ex_alu_op1_ctrl,
    output alu_src2_t             ex_alu_op2_ctrl,
    output alu_op_t               ex_alu_ctrl,
    output mem_op_t               ex_mem_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rs1_addr,
    output logic [REG_ADDR_W-1:0] ex_rs2_addr,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic [XLEN-1:0]       ex_reg1_data,
    output logic [XLEN-1:0]       ex_reg2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [XLEN-1:0]       ex_pc,
    output logic                  ex_valid_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]           bubble_cnt_o,
    output logic [31:0]           flush_cnt_o,
`endif
    output logic                  hazard_stall_o
);

    ctrl_t                 r_ctrl;
    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_rs1, r_rs2, r_rd;
    logic [XLEN-1:0]       r_reg1, r_reg2, r_imm, r_pc;

    ctrl_t w_id_ctrl;
    logic  w_load_use;
    logic  w_stall;

    assign w_id_ctrl = '{reg_do_write: id_reg_do_write_ctrl, mem_do_write: id_mem_do_write_ctrl,
                         mem_do_read: id_mem_do_read_ctrl, do_branch: id_do_branch,
                         do_jump: id_do_jump, comp: id_comp_ctrl, wr_src: id_reg_wr_src_ctrl,
                         op1: id_alu_op1_ctrl, op2: id_alu_op2_ctrl, alu: id_alu_ctrl,
                         mem: id_mem_ctrl};

    // A load in EX whose destination is read by the ID instruction; x0 never counts.
    assign w_load_use = r_ctrl.mem_do_read && r_valid && (r_rd != '0) && id_valid_i &&
                        ((id_rs1_used && (id_rs1_addr == r_rd)) ||
                         (id_rs2_used && (id_rs2_addr == r_rd)));
    assign w_stall        = w_load_use & ~flush_i & ~hold_i;
    assign hazard_stall_o = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= CTRL_NOP;
            r_valid <= 1'b0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_rd    <= '0;
            r_reg1  <= '0;
            r_reg2  <= '0;
            r_imm   <= '0;
            r_pc    <= '0;
        end else if (!hold_i) begin
            if (flush_i || w_load_use) begin
                r_ctrl  <= CTRL_NOP;
                r_valid <= 1'b0;
                r_rs1   <= '0;
                r_rs2   <= '0;
                r_rd    <= '0;
                r_reg1  <= '0;
                r_reg2  <= '0;
                r_imm   <= '0;
                r_pc    <= '0;
            end else begin
                // Invalid slots carry data through but never control side effects.
                r_ctrl  <= id_valid_i ? w_id_ctrl : CTRL_NOP;
                r_valid <= id_valid_i;
                r_rs1   <= id_rs1_addr;
                r_rs2   <= id_rs2_addr;
                r_rd    <= id_rd_addr;
                r_reg1  <= id_reg1_data;
                r_reg2  <= id_reg2_data;
                r_imm   <= id_imm;
                r_pc    <= id_pc;
            end
        end
    end

    assign ex_reg_do_write_ctrl = r_ctrl.reg_do_write;
    assign ex_mem_do_write_ctrl = r_ctrl.mem_do_write;
    assign ex_mem_do_read_ctrl  = r_ctrl.mem_do_read;
    assign ex_do_branch         = r_ctrl.do_branch;
    assign ex_do_jump           = r_ctrl.do_jump;
    assign ex_comp_ctrl         = r_ctrl.comp;
    assign ex_reg_wr_src_ctrl   = r_ctrl.wr_src;
    assign ex_alu_op1_ctrl      = r_ctrl.op1;
    assign ex_alu_op2_ctrl      = r_ctrl.op2;
    assign ex_alu_ctrl          = r_ctrl.alu;
    assign ex_mem_ctrl          = r_ctrl.mem;
    assign ex_rs1_addr          = r_rs1;
    assign ex_rs2_addr          = r_rs2;
    assign ex_rd_addr           = r_rd;
    assign ex_reg1_data         = r_reg1;
    assign ex_reg2_data         = r_reg2;
    assign ex_imm               = r_imm;
    assign ex_pc                = r_pc;
    assign ex_valid_o           = r_valid;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] r_bubble_cnt, r_flush_cnt;
    logic        w_take_flush;

    assign w_take_flush = flush_i & ~hold_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_stall && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_take_flush && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign bubble_cnt_o = r_bubble_cnt;
    assign flush_cnt_o  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg against an instruction-level model of EX contents.
module tb_id_ex_pipe_reg;
    import id_ex_pkg::*;

    typedef struct packed {
        ctrl_t       ctrl;
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] r1, r2, imm, pc;
    } id_in_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    logic   hold_i = 1'b0;
    logic   flush_i = 1'b0;
    id_in_t cur = '0;

    logic        ex_reg_do_write_ctrl, ex_mem_do_write_ctrl, ex_mem_do_read_ctrl;
    logic        ex_do_branch, ex_do_jump, ex_valid_o, hazard_stall_o;
    comp_op_t    ex_comp_ctrl;
    reg_wr_src_t ex_reg_wr_src_ctrl;
    alu_src1_t   ex_alu_op1_ctrl;
    alu_src2_t   ex_alu_op2_ctrl;
    alu_op_t     ex_alu_ctrl;
    mem_op_t     ex_mem_ctrl;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [31:0] ex_reg1_data, ex_reg2_data, ex_imm, ex_pc;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_o, flush_cnt_o;
`endif

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(cur.valid),
        .id_reg_do_write_ctrl(cur.ctrl.reg_do_write), .id_mem_do_write_ctrl(cur.ctrl.mem_do_write),
        .id_mem_do_read_ctrl(cur.ctrl.mem_do_read), .id_do_branch(cur.ctrl.do_branch),
        .id_do_jump(cur.ctrl.do_jump), .id_comp_ctrl(cur.ctrl.comp),
        .id_reg_wr_src_ctrl(cur.ctrl.wr_src), .id_alu_op1_ctrl(cur.ctrl.op1),
        .id_alu_op2_ctrl(cur.ctrl.op2), .id_alu_ctrl(cur.ctrl.alu), .id_mem_ctrl(cur.ctrl.mem),
        .id_rs1_addr(cur.rs1), .id_rs2_addr(cur.rs2), .id_rd_addr(cur.rd),
        .id_rs1_used(cur.u1), .id_rs2_used(cur.u2),
        .id_reg1_data(cur.r1), .id_reg2_data(cur.r2), .id_imm(cur.imm), .id_pc(cur.pc),
        .ex_reg_do_write_ctrl(ex_reg_do_write_ctrl), .ex_mem_do_write_ctrl(ex_mem_do_write_ctrl),
        .ex_mem_do_read_ctrl(ex_mem_do_read_ctrl), .ex_do_branch(ex_do_branch),
        .ex_do_jump(ex_do_jump), .ex_comp_ctrl(ex_comp_ctrl),
        .ex_reg_wr_src_ctrl(ex_reg_wr_src_ctrl), .ex_alu_op1_ctrl(ex_alu_op1_ctrl),
        .ex_alu_op2_ctrl(ex_alu_op2_ctrl), .ex_alu_ctrl(ex_alu_ctrl), .ex_mem_ctrl(ex_mem_ctrl),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
        .ex_reg1_data(ex_reg1_data), .ex_reg2_data(ex_reg2_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_valid_o(ex_valid_o),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o),
`endif
        .hazard_stall_o(hazard_stall_o)
    );

    ctrl_t dut_ctrl;
    assign dut_ctrl = '{reg_do_write: ex_reg_do_write_ctrl, mem_do_write: ex_mem_do_write_ctrl,
                        mem_do_read: ex_mem_do_read_ctrl, do_branch: ex_do_branch,
                        do_jump: ex_do_jump, comp: ex_comp_ctrl, wr_src: ex_reg_wr_src_ctrl,
                        op1: ex_alu_op1_ctrl, op2: ex_alu_op2_ctrl, alu: ex_alu_ctrl,
                        mem: ex_mem_ctrl};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Model: what instruction occupies EX, and which of its fields are defined by the rules.
    ctrl_t       m_ctrl;
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_r1, m_r2, m_imm, m_pc;
    bit          m_addr_known, m_data_known;
    longint      m_bub, m_fl;

    function automatic void model_reset();
        m_ctrl = CTRL_NOP; m_valid = 1'b0;
        m_rs1 = '0; m_rs2 = '0; m_rd = '0;
        m_r1 = '0; m_r2 = '0; m_imm = '0; m_pc = '0;
        m_addr_known = 1; m_data_known = 1;
        m_bub = 0; m_fl = 0;
    endfunction

    task automatic check_state();
        check_eq("ex_valid", ex_valid_o, m_valid);
        check_eq("ex_ctrl", dut_ctrl, m_ctrl);
        if (m_addr_known) begin
            check_eq("ex_addrs", {ex_rs1_addr, ex_rs2_addr, ex_rd_addr}, {m_rs1, m_rs2, m_rd});
        end
        if (m_data_known) begin
            check_eq("ex_ops", {ex_reg1_data, ex_reg2_data}, {m_r1, m_r2});
            check_eq("ex_imm_pc", {ex_imm, ex_pc}, {m_imm, m_pc});
        end
`ifdef ID_EX_PERF_CNT_EN
        check_eq("bubble_cnt", bubble_cnt_o, m_bub);
        check_eq("flush_cnt", flush_cnt_o, m_fl);
`endif
    endtask

    task automatic step(input id_in_t in, input logic h, input logic f, output logic stall_seen);
        logic lu;
        @(negedge clk);
        cur = in; hold_i = h; flush_i = f;
        #1;
        lu = m_valid && m_ctrl.mem_do_read && (m_rd != 5'd0) && in.valid &&
             ((in.u1 && in.rs1 == m_rd) || (in.u2 && in.rs2 == m_rd));
        stall_seen = hazard_stall_o;
        check_eq("hazard_stall", hazard_stall_o, lu && !f && !h);
        @(posedge clk);
        if (h) begin
        end else if (f) begin
            m_ctrl = CTRL_NOP; m_valid = 1'b0;
            m_rs1 = '0; m_rs2 = '0; m_rd = '0;
            m_addr_known = 1; m_data_known = 0;
            m_fl++;
        end else if (lu) begin
            m_ctrl = CTRL_NOP; m_valid = 1'b0;
            m_addr_known = 0; m_data_known = 0;
            m_bub++;
        end else begin
            m_ctrl = in.valid ? in.ctrl : CTRL_NOP;
            m_valid = in.valid;
            m_rs1 = in.rs1; m_rs2 = in.rs2; m_rd = in.rd;
            m_r1 = in.r1; m_r2 = in.r2; m_imm = in.imm; m_pc = in.pc;
            m_addr_known = in.valid; m_data_known = 1;
        end
        #1;
        check_state();
    endtask

    function automatic ctrl_t c_alu(input alu_op_t op, input alu_src2_t s2);
        ctrl_t c = CTRL_NOP;
        c.reg_do_write = 1'b1; c.alu = op; c.op2 = s2;
        return c;
    endfunction

    function automatic ctrl_t c_lw();
        ctrl_t c = c_alu(ALU_ADD, SRC2_IMM);
        c.mem_do_read = 1'b1; c.mem = MEM_LW; c.wr_src = WRSRC_MEMREAD;
        return c;
    endfunction

    function automatic ctrl_t c_sw();
        ctrl_t c = CTRL_NOP;
        c.alu = ALU_ADD; c.op2 = SRC2_IMM; c.mem_do_write = 1'b1; c.mem = MEM_SW;
        return c;
    endfunction

    function automatic id_in_t instr(input ctrl_t c, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic u1, input logic u2,
                                     input logic [31:0] imm, input logic [31:0] pc);
        id_in_t x;
        x.ctrl = c; x.valid = 1'b1; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.u1 = u1; x.u2 = u2;
        x.r1 = $urandom; x.r2 = $urandom; x.imm = imm; x.pc = pc;
        return x;
    endfunction

    function automatic id_in_t rand_in();
        id_in_t x;
        x.ctrl.reg_do_write = 1'($urandom_range(0, 1));
        x.ctrl.mem_do_write = 1'($urandom_range(0, 1));
        x.ctrl.mem_do_read  = ($urandom_range(0, 2) == 0);
        x.ctrl.do_branch    = 1'($urandom_range(0, 1));
        x.ctrl.do_jump      = 1'($urandom_range(0, 1));
        x.ctrl.comp   = comp_op_t'($urandom_range(0, 6));
        x.ctrl.wr_src = reg_wr_src_t'($urandom_range(0, 3));
        x.ctrl.op1    = alu_src1_t'($urandom_range(0, 2));
        x.ctrl.op2    = alu_src2_t'($urandom_range(0, 2));
        x.ctrl.alu    = alu_op_t'($urandom_range(0, 10));
        x.ctrl.mem    = mem_op_t'($urandom_range(0, 8));
        x.valid = ($urandom_range(0, 7) != 0);
        x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
        x.rd  = 5'($urandom_range(0, 3));
        x.u1 = 1'($urandom_range(0, 1)); x.u2 = 1'($urandom_range(0, 1));
        x.r1 = $urandom; x.r2 = $urandom; x.imm = $urandom; x.pc = $urandom;
        return x;
    endfunction

    initial begin
        logic   s;
        id_in_t lui;
        model_reset();
        #12;
        check_state();
        @(negedge clk);
        rst_n = 1'b1;

        // ADDI x5, x1, 12 at pc 0x40
        step(instr(c_alu(ALU_ADD, SRC2_IMM), 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 32'd12, 32'h40), 0, 0, s);
        check_eq("addi_alu", ex_alu_ctrl, ALU_ADD);
        check_eq("addi_op2", ex_alu_op2_ctrl, SRC2_IMM);
        check_eq("addi_imm_pc", {ex_imm, ex_pc}, {32'd12, 32'h40});

        // LW x3 then dependent ADD x4, x3, x2: one bubble, then ADD
        step(instr(c_lw(), 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 32'd8, 32'h44), 0, 0, s);
        step(instr(c_alu(ALU_ADD, SRC2_REG2), 5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 32'd0, 32'h48), 0, 0, s);
        check_eq("lu_stall", s, 1'b1);
        check_eq("lu_bubble_valid", ex_valid_o, 1'b0);
        step(instr(c_alu(ALU_ADD, SRC2_REG2), 5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 32'd0, 32'h48), 0, 0, s);
        check_eq("lu_cleared", s, 1'b0);
        check_eq("lu_add_in_ex", {ex_alu_ctrl, ex_rd_addr, ex_valid_o}, {ALU_ADD, 5'd4, 1'b1});

        // x0 destination and unused rs1 must not stall
        step(instr(c_lw(), 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 32'd0, 32'h4c), 0, 0, s);
        step(instr(c_alu(ALU_ADD, SRC2_REG2), 5'd4, 5'd0, 5'd0, 1'b1, 1'b1, 32'd0, 32'h50), 0, 0, s);
        check_eq("x0_no_stall", s, 1'b0);
        step(instr(c_lw(), 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 32'd0, 32'h54), 0, 0, s);
        lui = instr(c_alu(ALU_ADD, SRC2_IMM), 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 32'h1000, 32'h58);
        lui.ctrl.op1 = SRC1_ZERO;
        step(lui, 0, 0, s);
        check_eq("lui_no_stall", s, 1'b0);
        check_eq("lui_in_ex", {ex_valid_o, ex_pc}, {1'b1, 32'h58});

        // Flush wins over load-use
        step(instr(c_lw(), 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 32'd0, 32'h5c), 0, 0, s);
        step(instr(c_alu(ALU_ADD, SRC2_REG2), 5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 32'd0, 32'h60), 0, 1, s);
        check_eq("flush_no_stall", s, 1'b0);
        check_eq("flush_nop", {ex_valid_o, ex_mem_ctrl}, {1'b0, MEM_NOP});

        // Hold for 3 cycles with SW in EX
        step(instr(c_sw(), 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 32'd4, 32'h64), 0, 0, s);
        for (int i = 0; i < 3; i++) begin
            step(rand_in(), 1, 1'($urandom_range(0, 1)), s);
            check_eq("hold_sw", {ex_mem_ctrl, ex_pc}, {MEM_SW, 32'h64});
        end
        step(instr(c_alu(ALU_OR, SRC2_IMM), 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 32'd3, 32'h68), 0, 0, s);
        check_eq("hold_release", {ex_alu_ctrl, ex_pc}, {ALU_OR, 32'h68});

        for (int i = 0; i < 400; i++) begin
            step(rand_in(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), s);
        end

        // Asynchronous reset between edges
        step(instr(c_alu(ALU_ADD, SRC2_REG2), 5'd4, 5'd1, 5'd2, 1'b1, 1'b1, 32'd0, 32'h80), 0, 0, s);
        #2;
        rst_n = 1'b0;
        cur = '0; hold_i = 1'b0; flush_i = 1'b0;
        #1;
        model_reset();
        check_state();
        check_eq("rst_alu", ex_alu_ctrl, ALU_NOP);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(rand_in(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
